// File: rtl/mv_event_tx.sv
// Transmit side of the majority-vote event line.
// Turns req_i pulses into held-high bursts on d_o, strobed by sample_o for a
// downstream voting filter. Each burst is followed by a low guard gap and a
// one-cycle clear_o that rearms the filter. Requests arriving while busy are
// queued in a saturating pending counter.
//
// Optional build macro MV_EVENT_TX_ACK_EN: when defined, ack_i seen together
// with a sample strobe during the hold ends the burst early. When undefined,
// ack_i is ignored and every burst lasts exactly HOLD strobes.
module mv_event_tx #(
  parameter int unsigned DIV    = 4,   // clk cycles per sample strobe, >= 2
  parameter int unsigned HOLD   = 12,  // strobes d_o is held high per event, >= 1
  parameter int unsigned GAP    = 3,   // strobes d_o is held low before clear_o, >= 1
  parameter int unsigned PEND_W = 2    // pending counter width
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clear_i,
  input  logic              req_i,
  input  logic              ack_i,
  output logic              sample_o,
  output logic              d_o,
  output logic              clear_o,
  output logic              busy_o,
  output logic [PEND_W-1:0] pending_o,
  output logic              overflow_o
);

  localparam int unsigned DivW    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned TickMax = (HOLD > GAP) ? HOLD : GAP;
  localparam int unsigned TickW   = (TickMax > 1) ? $clog2(TickMax) : 1;

  localparam logic [DivW-1:0]   DivLast  = DivW'(DIV - 1);
  localparam logic [TickW-1:0]  HoldLast = TickW'(HOLD - 1);
  localparam logic [TickW-1:0]  GapLast  = TickW'(GAP - 1);
  localparam logic [PEND_W-1:0] PendMax  = {PEND_W{1'b1}};

  typedef enum logic [1:0] {
    StIdle,
    StAssert,
    StGap,
    StClear
  } state_e;

  state_e              state_q, state_d;
  logic [DivW-1:0]     div_q;
  logic [TickW-1:0]    tcnt_q, tcnt_d;
  logic [PEND_W-1:0]   pend_q, pend_d;
  logic                ovf_q, ovf_d;
  logic                d_q, d_d;
  logic                clr_q, clr_d;
  logic                sample;
  logic                hold_done;
  logic                pend_inc;
  logic                pend_dec;

  // ---------------------------------------------------------------------------
  // Prescaler
  // ---------------------------------------------------------------------------

  // Free-running divider; clear_i deliberately does not touch it so the
  // receiver keeps a steady strobe cadence across flushes.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_q <= '0;
    end else if (div_q == DivLast) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + 1'b1;
    end
  end

  assign sample = (div_q == DivLast);

  // ---------------------------------------------------------------------------
  // Early-termination qualifier
  // ---------------------------------------------------------------------------

`ifdef MV_EVENT_TX_ACK_EN
  // The receiver has already detected the event: the current strobe is the
  // last high one.
  assign hold_done = (tcnt_q == HoldLast) | ack_i;
`else
  logic unused_ack;
  assign unused_ack = ack_i;
  assign hold_done  = (tcnt_q == HoldLast);
`endif

  // ---------------------------------------------------------------------------
  // Pending counter and overflow flag
  // ---------------------------------------------------------------------------

  // Every CLEAR cycle retires one event. The guard on pend_q only matters if
  // the counter were somehow already empty.
  assign pend_inc = req_i;
  assign pend_dec = (state_q == StClear) && (pend_q != '0);

  // Saturating up/down counter; simultaneous inc and dec cancel out.
  always_comb begin
    pend_d = pend_q;
    ovf_d  = ovf_q;
    if (clear_i) begin
      pend_d = '0;
      ovf_d  = 1'b0;
    end else if (pend_inc && !pend_dec) begin
      if (pend_q == PendMax) begin
        ovf_d = 1'b1;
      end else begin
        pend_d = pend_q + 1'b1;
      end
    end else if (pend_dec && !pend_inc) begin
      pend_d = pend_q - 1'b1;
    end
  end

  // Pending and sticky overflow registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      pend_q <= pend_d;
      ovf_q  <= ovf_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Burst FSM
  // ---------------------------------------------------------------------------

  // State and tick counter registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
    end
  end

  // Next-state logic; clear_i overrides whatever the state machine decided.
  always_comb begin
    state_d = state_q;
    tcnt_d  = tcnt_q;
    unique case (state_q)
      StIdle: begin
        if ((pend_q != '0) || req_i) begin
          state_d = StAssert;
          tcnt_d  = '0;
        end
      end
      StAssert: begin
        if (sample) begin
          if (hold_done) begin
            state_d = StGap;
            tcnt_d  = '0;
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
      end
      StGap: begin
        if (sample) begin
          if (tcnt_q == GapLast) begin
            state_d = StClear;
            tcnt_d  = '0;
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
      end
      StClear: begin
        // Looks at the post-update count so a request landing on this cycle
        // chains straight into the next burst without an idle cycle.
        state_d = (pend_d != '0) ? StAssert : StIdle;
        tcnt_d  = '0;
      end
    endcase
    if (clear_i) begin
      state_d = StIdle;
      tcnt_d  = '0;
    end
  end

  // Output decode from the next state so d_o and clear_o come from flops.
  always_comb begin
    d_d   = (state_d == StAssert);
    clr_d = (state_d == StClear) || clear_i;
  end

  // Registered line and rearm outputs, free of decode glitches.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      d_q   <= 1'b0;
      clr_q <= 1'b0;
    end else begin
      d_q   <= d_d;
      clr_q <= clr_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------

  assign sample_o   = sample;
  assign d_o        = d_q;
  assign clear_o    = clr_q;
  assign busy_o     = (state_q != StIdle);
  assign pending_o  = pend_q;
  assign overflow_o = ovf_q;

endmodule

// File: tb/tb_mv_event_tx.sv
// Directed self-checking bench for mv_event_tx (DIV=4 HOLD=12 GAP=3 PEND_W=2).
module tb_mv_event_tx;

`ifdef MV_EVENT_TX_ACK_EN
  localparam int AckHi = 5;
`else
  localparam int AckHi = 12;
`endif

  logic       clk_i   = 1'b0;
  logic       rst_ni  = 1'b0;
  logic       clear_i = 1'b0;
  logic       req_i   = 1'b0;
  logic       ack_i   = 1'b0;
  logic       sample_o;
  logic       d_o;
  logic       clear_o;
  logic       busy_o;
  logic [1:0] pending_o;
  logic       overflow_o;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk_i = ~clk_i;

  mv_event_tx #(
    .DIV   (4),
    .HOLD  (12),
    .GAP   (3),
    .PEND_W(2)
  ) u_dut (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .clear_i   (clear_i),
    .req_i     (req_i),
    .ack_i     (ack_i),
    .sample_o  (sample_o),
    .d_o       (d_o),
    .clear_o   (clear_o),
    .busy_o    (busy_o),
    .pending_o (pending_o),
    .overflow_o(overflow_o)
  );

  task automatic check_eq(input string tag, input int got, input int exp);
    n_total++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the active edge.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Count high/low strobes from the current cycle until clear_o appears.
  // If ack_at is nonzero, ack_i is raised on the ack_at-th high strobe.
  task automatic measure_burst(input int ack_at, output int hi, output int lo);
    hi = 0;
    lo = 0;
    for (int i = 0; i < 400; i++) begin
      if (clear_o) break;
      if (sample_o) begin
        if (d_o) hi++;
        else     lo++;
      end
      ack_i = (ack_at != 0) && sample_o && d_o && (hi == ack_at);
      step();
    end
    ack_i = 1'b0;
    check_eq("burst_end_seen", int'(clear_o), 1);
  endtask

  // Run until the FSM is idle; returns number of clear_o cycles seen.
  task automatic drain(output int clears);
    clears = 0;
    for (int i = 0; i < 2000; i++) begin
      if (clear_o) clears++;
      if (!busy_o) break;
      step();
    end
    check_eq("drain_idle", int'(busy_o), 0);
  endtask

  initial begin
    int n;
    int hi;
    int lo;
    int clears;

    // Reset state.
    repeat (3) step();
    check_eq("rst_sample", int'(sample_o), 0);
    check_eq("rst_d", int'(d_o), 0);
    check_eq("rst_clear", int'(clear_o), 0);
    check_eq("rst_busy", int'(busy_o), 0);
    check_eq("rst_pending", int'(pending_o), 0);
    check_eq("rst_overflow", int'(overflow_o), 0);

    // Strobe timing after release.
    rst_ni = 1'b1;
    n = 0;
    do begin
      step();
      n++;
    end while (!sample_o && n < 20);
    check_eq("first_strobe_delay", n, 3);
    n = 0;
    do begin
      step();
      n++;
    end while (!sample_o && n < 20);
    check_eq("strobe_period", n, 4);

    // Single request.
    req_i = 1'b1;
    step();
    req_i = 1'b0;
    check_eq("single_d_latency", int'(d_o), 1);
    check_eq("single_busy", int'(busy_o), 1);
    check_eq("single_pending", int'(pending_o), 1);
    measure_burst(0, hi, lo);
    check_eq("single_hi_strobes", hi, 12);
    check_eq("single_lo_strobes", lo, 3);
    step();
    check_eq("single_clear_one_cycle", int'(clear_o), 0);
    check_eq("single_idle", int'(busy_o), 0);
    check_eq("single_pending_end", int'(pending_o), 0);

    // Five back-to-back requests saturate the counter.
    req_i = 1'b1;
    repeat (5) step();
    req_i = 1'b0;
    check_eq("sat_pending", int'(pending_o), 3);
    check_eq("sat_overflow", int'(overflow_o), 1);
    drain(clears);
    check_eq("sat_bursts", clears, 3);
    check_eq("sat_pending_end", int'(pending_o), 0);
    check_eq("sat_overflow_sticky", int'(overflow_o), 1);

    // Request on the CLEAR cycle chains straight into the next burst.
    req_i = 1'b1;
    step();
    req_i = 1'b0;
    n = 0;
    while (!clear_o && n < 400) begin
      step();
      n++;
    end
    check_eq("chain_clear_seen", int'(clear_o), 1);
    check_eq("chain_pending_on_clear", int'(pending_o), 1);
    req_i = 1'b1;
    step();
    req_i = 1'b0;
    check_eq("chain_pending", int'(pending_o), 1);
    check_eq("chain_busy", int'(busy_o), 1);
    check_eq("chain_d", int'(d_o), 1);
    check_eq("chain_clear_low", int'(clear_o), 0);
    drain(clears);
    check_eq("chain_bursts", clears, 1);
    check_eq("chain_pending_end", int'(pending_o), 0);

    // clear_i at the 6th high strobe with pending=2, overflow=1.
    req_i = 1'b1;
    repeat (2) step();
    req_i = 1'b0;
    check_eq("flush_pre_pending", int'(pending_o), 2);
    check_eq("flush_pre_overflow", int'(overflow_o), 1);
    hi = 0;
    for (int i = 0; i < 400; i++) begin
      if (sample_o && d_o) hi++;
      if (hi == 6) break;
      step();
    end
    check_eq("flush_reached_6th", hi, 6);
    clear_i = 1'b1;
    req_i   = 1'b1;
    step();
    clear_i = 1'b0;
    req_i   = 1'b0;
    check_eq("flush_d", int'(d_o), 0);
    check_eq("flush_busy", int'(busy_o), 0);
    check_eq("flush_pending", int'(pending_o), 0);
    check_eq("flush_overflow", int'(overflow_o), 0);
    check_eq("flush_clear_pulse", int'(clear_o), 1);
    step();
    check_eq("flush_clear_one_cycle", int'(clear_o), 0);
    check_eq("flush_req_discarded", int'(busy_o), 0);

    // ack_i on the 5th high strobe.
    req_i = 1'b1;
    step();
    req_i = 1'b0;
    measure_burst(5, hi, lo);
    check_eq("ack_hi_strobes", hi, AckHi);
    check_eq("ack_lo_strobes", lo, 3);
    step();
    check_eq("ack_idle", int'(busy_o), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
